iterative_multdiv_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 18 +
 rtl/div_restoring_step.sv | 25 ++
 rtl/iterative_multdiv_unit.sv | 146 ++++++++++++++
 tb/tb_iterative_multdiv_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam logic [MD_WIDTH-1:0] MD_MOST_NEG = {1'b1, {(MD_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it did not go negative.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    fits     = ~diff[WIDTH+1];
    rem_next = fits ? diff[WIDTH:0] : shifted;
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iterative_multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes),
// one iteration per clock, started by a rising edge on ctrl_MULT or ctrl_DIV.
module iterative_multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       debug_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  op_t              op;
  logic [CW-1:0]    counter;
  logic             prev_mult, prev_div;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q, mcand;
  logic             q_m1;
  logic             neg_quo, div_zero, div_ovf;

  logic             start_mult, start_div, start;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mcand_ext, booth_sum;
  logic [WIDTH:0]   div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic             mult_exc;

  assign debug_state = state;

  always_comb begin
    start_mult = ctrl_MULT & ~prev_mult;
    start_div  = ctrl_DIV & ~prev_div;
    start      = start_mult | start_div;
    a_mag      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // Accumulator carries one guard bit so adding/subtracting the most-negative multiplicand cannot wrap.
    mcand_ext  = {mcand[WIDTH-1], mcand};
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    mult_exc   = (acc[WIDTH-1:0] != {WIDTH{q[WIDTH-1]}});
  end

  div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[WIDTH-1:0]),
    .quo      (q),
    .divisor  (mcand),
    .rem_next (div_rem_next),
    .quo_next (div_quo_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op             <= OP_MULT;
      counter        <= '0;
      prev_mult      <= 1'b0;
      prev_div       <= 1'b0;
      acc            <= '0;
      q              <= '0;
      mcand          <= '0;
      q_m1           <= 1'b0;
      neg_quo        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      prev_mult      <= ctrl_MULT;
      prev_div       <= ctrl_DIV;
      data_resultRDY <= 1'b0;

      case (state)
        IDLE: ;
        RUN: begin
          counter <= counter + CW'(1);
          if (op == OP_MULT) begin
            {acc, q, q_m1} <= {booth_sum[WIDTH], booth_sum, q};
          end else begin
            acc <= div_rem_next;
            q   <= div_quo_next;
          end
          if (counter == LAST_STEP) state <= DONE;
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
          if (op == OP_MULT) begin
            data_result    <= q;
            data_exception <= mult_exc;
          end else if (div_zero) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else if (div_ovf) begin
            data_result    <= MIN_VAL;
            data_exception <= 1'b1;
          end else begin
            data_result    <= neg_quo ? -q : q;
            data_exception <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A start edge in any state (re)loads the datapath; in RUN this abandons the current op.
      if (start) begin
        state   <= RUN;
        busy    <= 1'b1;
        counter <= '0;
        acc     <= '0;
        q_m1    <= 1'b0;
        if (start_mult) begin
          op    <= OP_MULT;
          q     <= data_operandB;
          mcand <= data_operandA;
        end else begin
          op       <= OP_DIV;
          q        <= a_mag;
          mcand    <= b_mag;
          neg_quo  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          div_zero <= (data_operandB == '0);
          div_ovf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
        end
      end
    end
  end

endmodule

// File: tb/tb_iterative_multdiv_unit.sv
// Bench for iterative_multdiv_unit: directed vector table, randomized ops against
// an arithmetic reference model, and hand sequences for abort, hold, collision and reset.
module tb_iterative_multdiv_unit;
  import multdiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_operandA = '0, data_operandB = '0;
  logic         ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
  logic [1:0]   debug_state;

  iterative_multdiv_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .debug_state    (debug_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit           is_mult;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_r;
    bit           exp_e;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  logic [W:0]   exp_q[$];
  int           rdy_count;
  int           rdy_cycle;
  logic [W-1:0] got_r;
  logic         got_e;

  task automatic check(string name, logic [63:0] actual, logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, required);
    end
  endtask

  // Reference: plain signed arithmetic on wide integers.
  function automatic logic [W:0] ref_model(bit is_mult, logic [W-1:0] a, logic [W-1:0] b);
    longint       p;
    logic [W-1:0] lo;
    int           quot;
    if (is_mult) begin
      p  = longint'(signed'(a)) * longint'(signed'(b));
      lo = p[W-1:0];
      return {(p != longint'(signed'(lo))), lo};
    end
    if (b == 0) return {1'b1, {W{1'b0}}};
    if (a == MD_MOST_NEG && b == '1) return {1'b1, MD_MOST_NEG};
    quot = signed'(a) / signed'(b);
    return {1'b0, quot};
  endfunction

  task automatic tick(int k);
    @(posedge clock);
    #1;
    if (data_resultRDY === 1'b1) begin
      rdy_count++;
      rdy_cycle = k;
      got_r     = data_result;
      got_e     = data_exception;
    end
  endtask

  task automatic do_op(bit is_mult, logic [W-1:0] a, logic [W-1:0] b, string name);
    int         busy_bad;
    logic [W:0] exp;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mult;
    ctrl_DIV      = !is_mult;
    rdy_count = 0;
    rdy_cycle = -1;
    busy_bad  = 0;
    tick(0);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      tick(k);
      if (k <= 32 && busy !== 1'b1) busy_bad++;
      if (k == 33 && busy !== 1'b0) busy_bad++;
    end
    check({name, "_rdy_cycle"}, rdy_cycle, 33);
    check({name, "_rdy_count"}, rdy_count, 1);
    check({name, "_busy"}, busy_bad, 0);
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_result"}, got_r, exp[W-1:0]);
      check({name, "_exception"}, got_e, exp[W]);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[4] = '{1'b0, 32'd5,        32'd0,        32'h00000000, 1'b1};
    vecs[5] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 0);
    check("reset_exception", data_exception, 0);
    check("reset_rdy", data_resultRDY, 0);
    check("reset_busy", busy, 0);
    check("reset_state", debug_state, IDLE);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Directed vector table
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].exp_e, vecs[i].exp_r});
      do_op(vecs[i].is_mult, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    // Randomized ops checked against the reference model
    for (int i = 0; i < 24; i++) begin
      bit           m;
      logic [W-1:0] a, b;
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 5000); b = $urandom_range(1, 300); end
        2: begin a = -$urandom_range(0, 5000); b = $urandom_range(1, 300); end
        default: begin a = $urandom; b = (i % 3 == 0) ? '0 : -$urandom_range(1, 70000); end
      endcase
      exp_q.push_back(ref_model(m, a, b));
      do_op(m, a, b, $sformatf("rand%0d", i));
    end

    // Abort: multiply at E0, divide edge at E10 restarts; only the divide completes
    @(negedge clock);
    data_operandA = 32'd3; data_operandB = 32'd4; ctrl_MULT = 1'b1;
    rdy_count = 0; rdy_cycle = -1;
    tick(0);
    ctrl_MULT = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick(k);
      if (k == 9) begin data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1; end
      if (k == 10) ctrl_DIV = 1'b0;
    end
    check("abort_rdy_count", rdy_count, 1);
    check("abort_rdy_cycle", rdy_cycle, 43);
    check("abort_result", got_r, 14);
    check("abort_exception", got_e, 0);

    // Request level held for 80 cycles starts once
    @(negedge clock);
    data_operandA = 32'd5; data_operandB = 32'd6; ctrl_MULT = 1'b1;
    rdy_count = 0; rdy_cycle = -1;
    for (int k = 0; k < 80; k++) tick(k);
    ctrl_MULT = 1'b0;
    for (int k = 80; k < 90; k++) tick(k);
    check("hold_rdy_count", rdy_count, 1);
    check("hold_rdy_cycle", rdy_cycle, 33);
    check("hold_result", got_r, 30);

    // Simultaneous edges: multiply wins
    @(negedge clock);
    data_operandA = 32'd6; data_operandB = 32'd3; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    rdy_count = 0; rdy_cycle = -1;
    tick(0);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    for (int k = 1; k <= 40; k++) tick(k);
    check("both_rdy_count", rdy_count, 1);
    check("both_rdy_cycle", rdy_cycle, 33);
    check("both_result", got_r, 18);

    // Reset mid-multiply
    @(negedge clock);
    data_operandA = 32'd7; data_operandB = 32'd9; ctrl_MULT = 1'b1;
    rdy_count = 0;
    tick(0);
    ctrl_MULT = 1'b0;
    for (int k = 1; k <= 5; k++) tick(k);
    reset = 1'b0;
    #1;
    check("midrst_result", data_result, 0);
    check("midrst_exception", data_exception, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", debug_state, IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 50; k++) tick(k);
    check("midrst_no_rdy", rdy_count, 0);
    exp_q.push_back(ref_model(1'b1, 32'hFFFFFF00, 32'd77));
    do_op(1'b1, 32'hFFFFFF00, 32'd77, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
